// File: rtl/can_ack_slot_chk_if.sv
// Signal bundle between the bit-stream processor and the transmitter-side ACK checker.
// The checker receives the sample stream and the abort sources, and it returns the ACK verdicts.
interface can_ack_slot_chk_if #(
    parameter int CNT_W = 5
);
    logic             smpl_en;
    logic             sampled_bit;
    logic             ack_slt;
    logic             arbtr_sts;
    logic [1:0]       mode;
    logic             tx_success;
    logic             act_err_frm_tx;
    logic             psv_err_frm_tx;
    logic             ack_err;
    logic             ack_dlm_err;
    logic             ack_ok;
    logic             ack_busy;
    logic [CNT_W-1:0] ack_err_cnt;
    logic             ack_err_lim;

    modport master (
        output smpl_en, sampled_bit, ack_slt, arbtr_sts, mode,
               tx_success, act_err_frm_tx, psv_err_frm_tx,
        input  ack_err, ack_dlm_err, ack_ok, ack_busy, ack_err_cnt, ack_err_lim
    );

    modport slave (
        input  smpl_en, sampled_bit, ack_slt, arbtr_sts, mode,
               tx_success, act_err_frm_tx, psv_err_frm_tx,
        output ack_err, ack_dlm_err, ack_ok, ack_busy, ack_err_cnt, ack_err_lim
    );
endinterface

// File: rtl/can_ack_slot_chk.sv
// Transmitter-side ACK slot / ACK delimiter checker for CAN, CAN FD and CAN XL.
// It also keeps a saturating count of consecutive missing acknowledges for fault confinement.
module can_ack_slot_chk #(
    parameter int ACK_WIN   = 4,
    parameter int DELIM_LEN = 1,
    parameter int CNT_W     = 5,
    parameter int ERR_LIMIT = 16
) (
    input  logic              clk,
    input  logic              g_rst,
    can_ack_slot_chk_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SLOT, DELIM} state_t;

    state_t           state, state_nx;
    logic [3:0]       k, k_nx, win, win_nx, k_inc;
    logic [2:0]       d, d_nx;
    logic             seen, seen_nx, seen_acc;
    logic             dec_err, dec_dlm, dec_ok;
    logic             ack_err_q, ack_dlm_err_q, ack_ok_q;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic             abort, dom;

    assign abort = bus.tx_success | bus.act_err_frm_tx | bus.psv_err_frm_tx | ~bus.arbtr_sts;
    assign dom   = ~bus.sampled_bit;

    always_ff @(posedge clk or posedge g_rst) begin
        if (g_rst) begin
            state         <= IDLE;
            k             <= '0;
            d             <= '0;
            seen          <= 1'b0;
            win           <= '0;
            ack_err_q     <= 1'b0;
            ack_dlm_err_q <= 1'b0;
            ack_ok_q      <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state         <= state_nx;
            k             <= k_nx;
            d             <= d_nx;
            seen          <= seen_nx;
            win           <= win_nx;
            ack_err_q     <= dec_err;
            ack_dlm_err_q <= dec_dlm;
            ack_ok_q      <= dec_ok;
            cnt_q         <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        k_nx     = k;
        d_nx     = d;
        seen_nx  = seen;
        win_nx   = win;
        dec_err  = 1'b0;
        dec_dlm  = 1'b0;
        dec_ok   = 1'b0;
        k_inc    = k + 4'd1;
        seen_acc = seen | dom;
        if (!abort && bus.smpl_en) begin
            unique case (state)
                IDLE: begin
                    if (bus.ack_slt) begin
                        unique case (bus.mode)
                            2'b00:   win_nx = 4'd1;
                            2'b01:   win_nx = 4'd2;
                            default: win_nx = 4'(ACK_WIN);
                        endcase
                        k_nx    = 4'd1;
                        seen_nx = dom;
                        if (win_nx != 4'd1) begin
                            state_nx = SLOT;
                        end else if (dom) begin
                            d_nx     = '0;
                            state_nx = DELIM;
                        end else begin
                            dec_err = 1'b1;
                        end
                    end
                end
                SLOT: begin
                    // A recessive bit after the acknowledge closes the slot and is already delimiter bit 1
                    if (!dom && seen) begin
                        d_nx = 3'd1;
                        if (DELIM_LEN == 1) begin
                            dec_ok   = 1'b1;
                            state_nx = IDLE;
                        end else begin
                            state_nx = DELIM;
                        end
                    end else begin
                        seen_nx = seen_acc;
                        k_nx    = k_inc;
                        if (k_inc == win) begin
                            if (!seen_acc) begin
                                dec_err  = 1'b1;
                                state_nx = IDLE;
                            end else begin
                                d_nx     = '0;
                                state_nx = DELIM;
                            end
                        end
                    end
                end
                DELIM: begin
                    if (dom) begin
                        dec_dlm  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        d_nx = d + 3'd1;
                        if (d_nx == 3'(DELIM_LEN)) begin
                            dec_ok   = 1'b1;
                            state_nx = IDLE;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end else if (abort) begin
            state_nx = IDLE;
        end
        if (state_nx == IDLE) begin
            k_nx    = '0;
            d_nx    = '0;
            seen_nx = 1'b0;
        end
    end

    always_comb begin
        cnt_nx = cnt_q;
        if (dec_err) begin
            if (cnt_q != '1) cnt_nx = cnt_q + CNT_W'(1);
        end else if (dec_ok) begin
            cnt_nx = '0;
        end
    end

    assign bus.ack_err     = ack_err_q;
    assign bus.ack_dlm_err = ack_dlm_err_q;
    assign bus.ack_ok      = ack_ok_q;
    assign bus.ack_busy    = (state != IDLE);
    assign bus.ack_err_cnt = cnt_q;
    assign bus.ack_err_lim = (cnt_q >= CNT_W'(ERR_LIMIT));
endmodule
